// File: rtl/ebr_fifo.sv
// First-word-fall-through FIFO on an inferred registered-read block RAM.
// The RAM read register is the output stage, so RD_DATA comes straight from it.
module ebr_fifo #(
  parameter int DATA_WIDTH    = 16,
  parameter int DEPTH         = 256,
  parameter int AFULL_THRESH  = DEPTH - 4,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic                       CLK,
  input  logic                       RST_N,
  input  logic                       FLUSH,
  input  logic                       WR_VALID,
  output logic                       WR_READY,
  input  logic [DATA_WIDTH-1:0]      WR_DATA,
  output logic                       RD_VALID,
  input  logic                       RD_READY,
  output logic [DATA_WIDTH-1:0]      RD_DATA,
  output logic [$clog2(DEPTH):0]     LEVEL,
  output logic                       ALMOST_FULL,
  output logic                       ALMOST_EMPTY
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [LW-1:0] AFULL_L  = LW'(AFULL_THRESH);
  localparam logic [LW-1:0] AEMPTY_L = LW'(AEMPTY_THRESH);
  localparam logic [LW-1:0] ONE_L    = LW'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic [LW-1:0]         wptr_q, wptr_d;
  logic [LW-1:0]         rptr_q, rptr_d;
  logic [LW-1:0]         level_q, level_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  wr_fire, rd_fire, rd_issue, ram_empty;

  // Handshake: a word moves on a side in any cycle where valid and ready are
  // both high at the rising edge; neither side waits on the other's ready.
  always_comb begin
    WR_READY  = RST_N && !FLUSH && (level_q < DEPTH_L);
    wr_fire   = WR_VALID && WR_READY;
    rd_fire   = rd_valid_q && RD_READY && !FLUSH;
    ram_empty = (wptr_q == rptr_q);
    // The output register is refilled when it is empty or being consumed.
    rd_issue  = !FLUSH && !ram_empty && (!rd_valid_q || RD_READY);
  end

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    level_d    = level_q;
    rd_valid_d = rd_valid_q;
    if (FLUSH) begin
      wptr_d     = '0;
      rptr_d     = '0;
      level_d    = '0;
      rd_valid_d = 1'b0;
    end else begin
      if (wr_fire)  wptr_d = wptr_q + ONE_L;
      if (rd_issue) rptr_d = rptr_q + ONE_L;
      if (rd_issue)     rd_valid_d = 1'b1;
      else if (rd_fire) rd_valid_d = 1'b0;
      unique case ({wr_fire, rd_fire})
        2'b10:   level_d = level_q + ONE_L;
        2'b01:   level_d = level_q - ONE_L;
        default: level_d = level_q;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      level_q    <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      level_q    <= level_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // No reset on the array or read register so both map onto block RAM.
  always_ff @(posedge CLK) begin
    if (wr_fire)  mem_q[wptr_q[AW-1:0]] <= WR_DATA;
    if (rd_issue) rd_data_q <= mem_q[rptr_q[AW-1:0]];
  end

  always_comb begin
    RD_VALID     = rd_valid_q;
    RD_DATA      = rd_data_q;
    LEVEL        = level_q;
    ALMOST_FULL  = (level_q >= AFULL_L);
    ALMOST_EMPTY = (level_q <= AEMPTY_L);
  end

endmodule

// File: tb/tb_ebr_fifo.sv
// Bench for ebr_fifo: directed vectors on a 16x16 instance, then random
// traffic on 16x16, 4x32 and 512x1 instances against a count/array model.
module tb_ebr_fifo;

  localparam int DEP [3] = '{16, 4, 512};
  localparam int DWD [3] = '{16, 32, 1};
  localparam int AFT [3] = '{12, 3, 508};
  localparam int AET [3] = '{4, 1, 4};

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic fl [3];
  logic wv [3];
  logic rr [3];
  logic [31:0] wd [3];

  logic wrdy [3];
  logic rvld [3];
  logic af [3];
  logic ae [3];
  logic [31:0] rdat [3];
  logic [31:0] lvl [3];

  logic        wrdy0, wrdy1, wrdy2, rvld0, rvld1, rvld2;
  logic        af0, af1, af2, ae0, ae1, ae2;
  logic [15:0] rd0;
  logic [31:0] rd1;
  logic        rd2;
  logic [4:0]  l0;
  logic [2:0]  l1;
  logic [9:0]  l2;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ebr_fifo #(.DATA_WIDTH(16), .DEPTH(16), .AFULL_THRESH(12), .AEMPTY_THRESH(4)) u_dut0 (
    .CLK(clk), .RST_N(rst_n), .FLUSH(fl[0]), .WR_VALID(wv[0]), .WR_READY(wrdy0),
    .WR_DATA(wd[0][15:0]), .RD_VALID(rvld0), .RD_READY(rr[0]), .RD_DATA(rd0),
    .LEVEL(l0), .ALMOST_FULL(af0), .ALMOST_EMPTY(ae0));

  ebr_fifo #(.DATA_WIDTH(32), .DEPTH(4), .AFULL_THRESH(3), .AEMPTY_THRESH(1)) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .FLUSH(fl[1]), .WR_VALID(wv[1]), .WR_READY(wrdy1),
    .WR_DATA(wd[1]), .RD_VALID(rvld1), .RD_READY(rr[1]), .RD_DATA(rd1),
    .LEVEL(l1), .ALMOST_FULL(af1), .ALMOST_EMPTY(ae1));

  ebr_fifo #(.DATA_WIDTH(1), .DEPTH(512), .AFULL_THRESH(508), .AEMPTY_THRESH(4)) u_dut2 (
    .CLK(clk), .RST_N(rst_n), .FLUSH(fl[2]), .WR_VALID(wv[2]), .WR_READY(wrdy2),
    .WR_DATA(wd[2][0]), .RD_VALID(rvld2), .RD_READY(rr[2]), .RD_DATA(rd2),
    .LEVEL(l2), .ALMOST_FULL(af2), .ALMOST_EMPTY(ae2));

  always_comb begin
    wrdy[0] = wrdy0; wrdy[1] = wrdy1; wrdy[2] = wrdy2;
    rvld[0] = rvld0; rvld[1] = rvld1; rvld[2] = rvld2;
    af[0] = af0; af[1] = af1; af[2] = af2;
    ae[0] = ae0; ae[1] = ae1; ae[2] = ae2;
    rdat[0] = 32'(rd0); rdat[1] = rd1; rdat[2] = 32'(rd2);
    lvl[0] = 32'(l0); lvl[1] = 32'(l1); lvl[2] = 32'(l2);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- reference model (random phase) ----------------
  logic [31:0] m_mem [3][512];
  int          m_head [3];
  int          m_cnt [3];
  bit          m_pres [3];

  function automatic logic [31:0] dmask(input int k);
    return (DWD[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << DWD[k]) - 32'd1);
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      m_head[k] = 0; m_cnt[k] = 0; m_pres[k] = 1'b0;
    end
  endtask

  task automatic model_check(input int k);
    chk($sformatf("rnd%0d_level", k), lvl[k], 32'(m_cnt[k]));
    chk($sformatf("rnd%0d_wr_ready", k), 32'(wrdy[k]), 32'(!fl[k] && m_cnt[k] < DEP[k]));
    chk($sformatf("rnd%0d_rd_valid", k), 32'(rvld[k]), 32'(m_pres[k]));
    chk($sformatf("rnd%0d_afull", k), 32'(af[k]), 32'(m_cnt[k] >= AFT[k]));
    chk($sformatf("rnd%0d_aempty", k), 32'(ae[k]), 32'(m_cnt[k] <= AET[k]));
    if (m_pres[k])
      chk($sformatf("rnd%0d_data", k), rdat[k], m_mem[k][m_head[k]]);
  endtask

  // Words held = m_cnt; the oldest sits in the output stage when m_pres.
  task automatic model_step(input int k);
    bit wf, rf;
    int ram_words;
    if (fl[k]) begin
      m_cnt[k] = 0; m_head[k] = 0; m_pres[k] = 1'b0;
    end else begin
      wf = wv[k] && (m_cnt[k] < DEP[k]);
      rf = m_pres[k] && rr[k];
      ram_words = m_cnt[k] - int'(m_pres[k]);
      if (wf) m_mem[k][(m_head[k] + m_cnt[k]) % DEP[k]] = wd[k] & dmask(k);
      if (rf) m_head[k] = (m_head[k] + 1) % DEP[k];
      m_cnt[k] = m_cnt[k] + int'(wf) - int'(rf);
      m_pres[k] = (m_pres[k] && !rr[k]) || (ram_words > 0 && (!m_pres[k] || rr[k]));
    end
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        wv;
    logic [15:0] wd;
    logic        rr;
    logic        fl;
    logic        e_wrdy;
    logic        e_rvld;
    int          e_lvl;
    logic        e_af;
    logic        e_ae;
    logic        chk_d;
    logic [15:0] e_d;
  } vec_t;

  vec_t tbl [$];
  logic [15:0] exp_q [$];

  function automatic vec_t mk(logic v, logic [15:0] d, logic r, logic f, logic ew, logic ev,
                              int el, logic ea, logic ee, logic cd, logic [15:0] ed);
    vec_t t;
    t.wv = v; t.wd = d; t.rr = r; t.fl = f; t.e_wrdy = ew; t.e_rvld = ev; t.e_lvl = el;
    t.e_af = ea; t.e_ae = ee; t.chk_d = cd; t.e_d = ed;
    return t;
  endfunction

  task automatic drive0(input logic v, input logic [15:0] d, input logic r, input logic f);
    wv[0] = v; wd[0] = 32'(d); rr[0] = r; fl[0] = f;
  endtask

  task automatic zero_inputs();
    for (int k = 0; k < 3; k++) begin
      fl[k] = 1'b0; wv[k] = 1'b0; rr[k] = 1'b0; wd[k] = '0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int got;
    logic [15:0] seq [16];
    zero_inputs();
    model_clear();

    // Reset behaviour
    repeat (3) @(negedge clk);
    #1;
    chk("rst_wr_ready", 32'(wrdy0), 32'd0);
    chk("rst_rd_valid", 32'(rvld0), 32'd0);
    chk("rst_level", 32'(l0), 32'd0);
    chk("rst_aempty", 32'(ae0), 32'd1);
    chk("rst_afull", 32'(af0), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_release_wr_ready", 32'(wrdy0), 32'd1);

    // Single word, then stall, then one read pulse
    tbl.push_back(mk(1, 16'hA5C3, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 16'hA5C3));
    for (int i = 0; i < 10; i++) tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 16'hA5C3));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 1, 0, 1, 1, 16'hA5C3));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    // Nine words, then flush with a write offered
    for (int i = 0; i < 9; i++)
      tbl.push_back(mk(1, 16'(16'h10 + i), 0, 0, 1, logic'(i >= 2), i, 0, logic'(i <= 4),
                       logic'(i >= 2), 16'h0010));
    tbl.push_back(mk(1, 16'h1111, 0, 1, 0, 1, 9, 0, 0, 1, 16'h0010));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    for (int i = 0; i < 3; i++) tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    // Single word with read and write in the same cycle: bubble then refill
    tbl.push_back(mk(1, 16'h2222, 0, 0, 1, 0, 0, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 16'h2222));
    tbl.push_back(mk(1, 16'h3333, 1, 0, 1, 1, 1, 0, 1, 1, 16'h2222));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 1, 0, 1, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 1, 0, 1, 1, 16'h3333));
    tbl.push_back(mk(0, 0, 1, 0, 1, 1, 1, 0, 1, 1, 16'h3333));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0));

    foreach (tbl[i]) begin
      @(negedge clk);
      drive0(tbl[i].wv, tbl[i].wd, tbl[i].rr, tbl[i].fl);
      #1;
      chk($sformatf("vec%0d_wr_ready", i), 32'(wrdy0), 32'(tbl[i].e_wrdy));
      chk($sformatf("vec%0d_rd_valid", i), 32'(rvld0), 32'(tbl[i].e_rvld));
      chk($sformatf("vec%0d_level", i), 32'(l0), 32'(tbl[i].e_lvl));
      chk($sformatf("vec%0d_afull", i), 32'(af0), 32'(tbl[i].e_af));
      chk($sformatf("vec%0d_aempty", i), 32'(ae0), 32'(tbl[i].e_ae));
      if (tbl[i].chk_d) chk($sformatf("vec%0d_data", i), 32'(rd0), 32'(tbl[i].e_d));
    end

    // Fill to full, offer one more word, drain 8, refill across the wrap
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      drive0(1, 16'(i), 0, 0);
      #1;
      chk("fill_wr_ready", 32'(wrdy0), 32'd1);
      chk("fill_afull", 32'(af0), 32'(i >= 12));
    end
    @(negedge clk);
    drive0(1, 16'h0099, 0, 0);
    #1;
    chk("full_level", 32'(l0), 32'd16);
    chk("full_wr_ready", 32'(wrdy0), 32'd0);
    chk("full_afull", 32'(af0), 32'd1);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      drive0(0, 0, 1, 0);
      #1;
      chk("drain_rd_valid", 32'(rvld0), 32'd1);
      chk("drain_data", 32'(rd0), 32'(j));
      if (j == 0) chk("full_read_wr_ready", 32'(wrdy0), 32'd0);
      if (j == 1) chk("after_full_read_wr_ready", 32'(wrdy0), 32'd1);
    end
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      drive0(1, 16'(100 + j), 0, 0);
      #1;
      chk("wrap_wr_ready", 32'(wrdy0), 32'd1);
    end
    for (int j = 0; j < 8; j++) begin
      seq[j] = 16'(8 + j);
      seq[j + 8] = 16'(100 + j);
    end
    got = 0;
    for (int c = 0; c < 40 && got < 16; c++) begin
      @(negedge clk);
      drive0(0, 0, 1, 0);
      #1;
      if (rvld0) begin
        chk("wrap_data", 32'(rd0), 32'(seq[got]));
        got++;
      end
    end
    chk("wrap_read_count", 32'(got), 32'd16);
    @(negedge clk);
    drive0(0, 0, 0, 0);
    #1;
    chk("wrap_end_level", 32'(l0), 32'd0);

    // Streaming: one write and one read every cycle
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      drive0(1, 16'(c), 1, 0);
      exp_q.push_back(16'(c));
      #1;
      if (c == 1) chk("stream_first_rd_valid", 32'(rvld0), 32'd0);
      if (c >= 2) begin
        chk("stream_rd_valid", 32'(rvld0), 32'd1);
        chk("stream_level", 32'(l0), 32'd2);
        if (rvld0) chk("stream_data", 32'(rd0), 32'(exp_q.pop_front()));
      end
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      drive0(0, 0, 1, 0);
      #1;
      if (rvld0) begin
        if (exp_q.size() == 0) chk("stream_extra_word", 32'(rd0), 32'hFFFF_FFFF);
        else chk("stream_tail_data", 32'(rd0), 32'(exp_q.pop_front()));
      end
    end
    chk("stream_leftover", 32'(exp_q.size()), 32'd0);
    chk("stream_end_level", 32'(l0), 32'd0);

    // Random traffic on all three instances
    @(negedge clk);
    rst_n = 1'b0;
    zero_inputs();
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int cyc = 0; cyc < 30000; cyc++) begin
      int wp, rp, ph;
      @(negedge clk);
      if (cyc == 17321) begin
        rst_n = 1'b0;
        zero_inputs();
        #1;
        for (int k = 0; k < 3; k++) begin
          chk($sformatf("midrst%0d_wr_ready", k), 32'(wrdy[k]), 32'd0);
          chk($sformatf("midrst%0d_rd_valid", k), 32'(rvld[k]), 32'd0);
          chk($sformatf("midrst%0d_level", k), lvl[k], 32'd0);
        end
        model_clear();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
      end
      ph = (cyc / 1500) % 3;
      wp = (ph == 0) ? 90 : (ph == 1) ? 35 : 70;
      rp = (ph == 0) ? 35 : (ph == 1) ? 90 : 70;
      for (int k = 0; k < 3; k++) begin
        fl[k] = ($urandom_range(0, 499) == 0);
        wv[k] = ($urandom_range(0, 99) < wp);
        rr[k] = ($urandom_range(0, 99) < rp);
        wd[k] = $urandom() & dmask(k);
      end
      #1;
      for (int k = 0; k < 3; k++) begin
        model_check(k);
        model_step(k);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
